i2c_slave: RTL and testbench

- I2C target (responder) for the single-byte master on the same bus: 7-bit addressing, write (master->slave) and read (slave->master) transfers.
- Samples SCL/SDA on the system clock, detects START/STOP, ACKs its own address, and delivers or supplies data bytes through a simple strobe interface to local logic.
- Open-drain on SDA: pulls low or releases, never drives high.

---
 rtl/i2c_slave.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target for 7-bit addressing, single- and multi-byte write/read.
// SCL and SDA pass through a synchronizer before edge detection. SDA is open-drain:
// the core only pulls it low or releases it, and it never changes SDA while SCL is high.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample stability filter
// after the synchronizers. This adds 2 clk of detection latency and suppresses
// pulses of 2 clk or shorter.
// Ports:
//   clk      - system clock, at least 16x the SCL frequency
//   areset   - asynchronous active-high reset
//   scl      - I2C clock from the master
//   sda      - I2C data, open-drain (0 or Z)
//   tx_data  - byte returned on the next read byte, captured when tx_load pulses
//   tx_load  - one-cycle pulse when tx_data is captured
//   rx_data  - last byte received in a write transfer
//   rx_valid - one-cycle pulse when rx_data updates
//   addr_hit - high from the address ACK until STOP or START
//   rw_out   - R/W bit of the current selected transfer (1 = read)
//   busy     - high from START to STOP, for any address
module i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_hit,
  output logic       rw_out,
  output logic       busy
);

  localparam int unsigned SYNC_W = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_RX        = 3'd3;
  localparam logic [2:0] S_RX_ACK    = 3'd4;
  localparam logic [2:0] S_TX        = 3'd5;
  localparam logic [2:0] S_TX_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic [SYNC_W-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_W-1:0] sda_sync_q, sda_sync_d;
  logic              scl_raw, sda_raw;
  logic              scl_s, sda_s;
  logic              scl_p_q, scl_p_d;
  logic              sda_p_q, sda_p_d;
  logic              fall_dly_q, fall_dly_d;
  logic              scl_rise, scl_fall, start_det, stop_det;

  logic [2:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       addr_hit_q, addr_hit_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;

  // Synchronizer shift chains; the oldest stage is the synchronized sample.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_W-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_W-2:0], sda};
  end

  assign scl_raw = scl_sync_q[SYNC_W-1];
  assign sda_raw = sda_sync_q[SYNC_W-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, scl_hist_d;
  logic [1:0] sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d;
  logic       sda_filt_q, sda_filt_d;

  // The filtered value follows the input once the current sample and the two
  // previous samples agree.
  always_comb begin
    scl_hist_d = {scl_hist_q[0], scl_raw};
    sda_hist_d = {sda_hist_q[0], sda_raw};
    scl_filt_d = scl_filt_q;
    sda_filt_d = sda_filt_q;
    if (scl_raw == scl_hist_q[0] && scl_raw == scl_hist_q[1]) scl_filt_d = scl_raw;
    if (sda_raw == sda_hist_q[0] && sda_raw == sda_hist_q[1]) sda_filt_d = sda_raw;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_s = scl_filt_d;
  assign sda_s = sda_filt_d;
`else
  assign scl_s = scl_raw;
  assign sda_s = sda_raw;
`endif

  // Bus events. START/STOP require SCL high in both samples, so an SCL edge
  // is never mistaken for a bus condition.
  assign scl_rise  = scl_s & ~scl_p_q;
  assign scl_fall  = ~scl_s & scl_p_q;
  assign start_det = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_det  = scl_s & scl_p_q & ~sda_p_q & sda_s;

  // SDA changes one clk after the synchronized falling edge.
  always_comb begin
    scl_p_d    = scl_s;
    sda_p_d    = sda_s;
    fall_dly_d = scl_fall;
  end

  // Protocol FSM. START and STOP take priority over every state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    addr_hit_d = addr_hit_q;
    rw_d       = rw_q;
    busy_d     = busy_q;

    if (stop_det) begin
      state_d    = S_IDLE;
      cnt_d      = 3'd7;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      addr_hit_d = 1'b0;
    end else if (start_det) begin
      state_d    = S_ADDR;
      cnt_d      = 3'd7;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b1;
      addr_hit_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_oe_d = 1'b0;
        end

        S_ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              cnt_d = 3'd7;
              // General call (address 0) is never acknowledged.
              if (shift_d[7:1] == SLAVE_ADDR && shift_d[7:1] != 7'd0) begin
                rw_d    = shift_d[0];
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_WAIT_STOP;
              end
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        // The first falling edge starts the ACK; the second one ends it.
        S_ADDR_ACK: begin
          if (fall_dly_q) begin
            if (!sda_oe_q) begin
              sda_oe_d   = 1'b1;
              addr_hit_d = 1'b1;
            end else if (rw_q) begin
              tx_load_d = 1'b1;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[7];
              state_d   = S_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_RX;
            end
          end
        end

        S_RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              cnt_d      = 3'd7;
              rx_data_d  = shift_d;
              rx_valid_d = 1'b1;
              state_d    = S_RX_ACK;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end

        S_RX_ACK: begin
          if (fall_dly_q) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_RX;
            end
          end
        end

        // cnt_q indexes the bit on the wire. It wraps back to 7 after the
        // 8th rising edge, and that wrap marks the end of the byte.
        S_TX: begin
          if (scl_rise) begin
            cnt_d = (cnt_q == 3'd0) ? 3'd7 : cnt_q - 3'd1;
          end else if (fall_dly_q) begin
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              state_d  = S_TX_ACK;
            end else begin
              sda_oe_d = ~shift_q[cnt_q];
            end
          end
        end

        S_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = S_WAIT_STOP;
          end else if (fall_dly_q) begin
            tx_load_d = 1'b1;
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[7];
            state_d   = S_TX;
          end
        end

        S_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      fall_dly_q <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= 3'd7;
      shift_q    <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      addr_hit_q <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
      fall_dly_q <= fall_dly_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      addr_hit_q <= addr_hit_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
    end
  end

  // Open-drain: pull low or release. The async reset clears sda_oe_q at once.
  assign sda      = sda_oe_q ? 1'b0 : 1'bz;
  assign tx_load  = tx_load_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign addr_hit = addr_hit_q;
  assign rw_out   = rw_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave. A table of single-byte
// transactions is applied in a loop. Hand-written sequences then cover a
// multi-byte write, a repeated START inside a byte, and a reset during the ACK.
module tb_i2c_slave;

  localparam int Q = 50;  // quarter SCL period in ns (SCL period 200 ns = 20 clk)

  logic       clk = 1'b0;
  logic       areset;
  logic       scl_m;
  logic       sda_m;
  wire        sda;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       rw_out;
  logic       busy;

  assign sda = sda_m ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .areset   (areset),
    .scl      (scl_m),
    .sda      (sda),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addr_hit (addr_hit),
    .rw_out   (rw_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe monitor: counts pulses and records every received byte.
  int         rxv_cnt = 0;
  int         tl_cnt  = 0;
  logic [7:0] rx_hist [0:63];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_hist[rxv_cnt & 63] = rx_data;
      rxv_cnt = rxv_cnt + 1;
    end
    if (tx_load) tl_cnt = tl_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Master bus primitives. Each bit starts with SCL low.
  task automatic start_cond();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(2*Q);
    sda_m = 1'b0; #(2*Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(2*Q);
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    acked = ~a;
  endtask

  task automatic read_byte(output logic [7:0] b, input logic ack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      read_bit(x);
      b[i] = x;
    end
    write_bit(~ack);
  endtask

  typedef struct {
    logic [7:0] addr_byte;  // address + R/W
    logic [7:0] data;       // byte written, or tx_data offered on read
    logic       exp_ack;
    logic [7:0] exp_data;   // byte received by slave, or read by master
    int         exp_rxv;
    int         exp_tl;
    logic       exp_hit;
    logic       exp_rw;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] mb   [3];

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         rxv0;
    int         tl0;

    vecs[0] = '{8'hA0, 8'hA5, 1'b1, 8'hA5, 1, 0, 1'b1, 1'b0};  // write 0xA5
    vecs[1] = '{8'hA1, 8'h3C, 1'b1, 8'h3C, 0, 1, 1'b1, 1'b1};  // read 0x3C
    vecs[2] = '{8'hA2, 8'hFF, 1'b0, 8'h00, 0, 0, 1'b0, 1'b1};  // 0x51: no ack
    vecs[3] = '{8'h00, 8'h12, 1'b0, 8'h00, 0, 0, 1'b0, 1'b1};  // general call
    vecs[4] = '{8'hA0, 8'h00, 1'b1, 8'h00, 1, 0, 1'b1, 1'b0};  // write 0x00
    vecs[5] = '{8'hA1, 8'hC3, 1'b1, 8'hC3, 0, 1, 1'b1, 1'b1};  // read 0xC3
    mb[0] = 8'h11; mb[1] = 8'h22; mb[2] = 8'h33;

    areset  = 1'b1;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    tx_data = 8'h00;
    #22;
    check("rst_sda",      sda,      1'b1);
    check("rst_rx_data",  rx_data,  8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_load",  tx_load,  1'b0);
    check("rst_addr_hit", addr_hit, 1'b0);
    check("rst_rw_out",   rw_out,   1'b0);
    check("rst_busy",     busy,     1'b0);
    #28;
    areset = 1'b0;
    #100;

    for (int i = 0; i < 6; i++) begin
      rxv0    = rxv_cnt;
      tl0     = tl_cnt;
      tx_data = vecs[i].data;
      start_cond();
      write_byte(vecs[i].addr_byte, ack);
      check($sformatf("v%0d_addr_ack", i), ack, vecs[i].exp_ack);
      if (vecs[i].addr_byte[0]) begin
        read_byte(rd, 1'b0);
        check($sformatf("v%0d_read_data", i), rd, vecs[i].exp_data);
      end else begin
        write_byte(vecs[i].data, ack);
        check($sformatf("v%0d_data_ack", i), ack, vecs[i].exp_ack);
      end
      #(4*Q);
      check($sformatf("v%0d_rx_valid_cnt", i), rxv_cnt - rxv0, vecs[i].exp_rxv);
      if (vecs[i].exp_rxv > 0)
        check($sformatf("v%0d_rx_data", i), rx_hist[(rxv_cnt - 1) & 63], vecs[i].exp_data);
      check($sformatf("v%0d_tx_load_cnt", i), tl_cnt - tl0, vecs[i].exp_tl);
      check($sformatf("v%0d_addr_hit", i), addr_hit, vecs[i].exp_hit);
      check($sformatf("v%0d_rw_out", i), rw_out, vecs[i].exp_rw);
      check($sformatf("v%0d_busy", i), busy, 1'b1);
      check($sformatf("v%0d_sda_released", i), sda, 1'b1);
      stop_cond();
      #(4*Q);
      check($sformatf("v%0d_busy_after_stop", i), busy, 1'b0);
      check($sformatf("v%0d_hit_after_stop", i), addr_hit, 1'b0);
    end

    // Multi-byte write: every byte is acknowledged and delivered in order.
    rxv0 = rxv_cnt;
    start_cond();
    write_byte(8'hA0, ack);
    check("mb_addr_ack", ack, 1'b1);
    for (int k = 0; k < 3; k++) begin
      write_byte(mb[k], ack);
      check($sformatf("mb_ack%0d", k), ack, 1'b1);
    end
    check("mb_rx_valid_cnt", rxv_cnt - rxv0, 3);
    for (int k = 0; k < 3; k++)
      check($sformatf("mb_rx_data%0d", k), rx_hist[(rxv0 + k) & 63], mb[k]);
    check("mb_addr_hit", addr_hit, 1'b1);
    stop_cond();
    #(4*Q);

    // Repeated START after 4 data bits: the partial byte is discarded.
    rxv0    = rxv_cnt;
    tl0     = tl_cnt;
    tx_data = 8'h81;
    start_cond();
    write_byte(8'hA0, ack);
    check("rs_addr_w_ack", ack, 1'b1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    start_cond();
    check("rs_hit_cleared", addr_hit, 1'b0);
    write_byte(8'hA1, ack);
    check("rs_addr_r_ack", ack, 1'b1);
    read_byte(rd, 1'b0);
    check("rs_read_data", rd, 8'h81);
    check("rs_rx_valid_cnt", rxv_cnt - rxv0, 0);
    check("rs_tx_load_cnt", tl_cnt - tl0, 1);
    check("rs_rw_out", rw_out, 1'b1);
    stop_cond();
    #(4*Q);

    // Reset while the slave pulls SDA low for the address ACK.
    start_cond();
    for (int i = 7; i >= 0; i--) write_bit(rd[0] & 1'b0 | ((8'hA0 >> i) & 1) != 0);
    sda_m = 1'b1;
    #20;
    check("ack_phase_sda_low", sda, 1'b0);
    check("ack_phase_hit", addr_hit, 1'b1);
    areset = 1'b1;
    #1;
    check("arst_sda_released", sda, 1'b1);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_addr_hit", addr_hit, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_rw_out", rw_out, 1'b0);
    check("arst_rx_valid", rx_valid, 1'b0);
    check("arst_tx_load", tx_load, 1'b0);
    #29;
    areset = 1'b0;
    #(2*Q);
    stop_cond();
    #(4*Q);
    rxv0 = rxv_cnt;
    start_cond();
    write_byte(8'hA0, ack);
    check("post_rst_addr_ack", ack, 1'b1);
    write_byte(8'h5A, ack);
    check("post_rst_data_ack", ack, 1'b1);
    check("post_rst_rx_valid_cnt", rxv_cnt - rxv0, 1);
    check("post_rst_rx_data", rx_data, 8'h5A);
    stop_cond();
    #(4*Q);
    check("post_rst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
